fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arbiter.sv | 137 +++++++++++++
 tb/tb_fetch_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one fetch port between read and write controllers; one fetch in flight.
// Latency: req in IDLE -> fetch_req next cycle; fetch_done -> owner done pulse next cycle; fetch_gnt low holds ISSUE.
module fetch_arbiter #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  localparam int TW = (list_depth > 1) ? $clog2(list_depth) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_fetch_req,
  input  logic [1:0]            rd_fetch_cmd,
  input  logic [TW-1:0]         rd_fetch_tag,
  input  logic [addr_width-1:0] rd_fetch_addr,
  output logic                  rd_fetch_gnt,
  output logic                  rd_fetch_done,
  input  logic                  wr_fetch_req,
  input  logic [1:0]            wr_fetch_cmd,
  input  logic [TW-1:0]         wr_fetch_tag,
  input  logic [addr_width-1:0] wr_fetch_addr,
  output logic                  wr_fetch_gnt,
  output logic                  wr_fetch_done,
  output logic                  fetch_req,
  output logic [1:0]            fetch_cmd,
  output logic [TW-1:0]         fetch_tag,
  output logic [addr_width-1:0] fetch_addr,
  output logic                  fetch_src,
  input  logic                  fetch_gnt,
  input  logic                  fetch_done,
  output logic                  busy,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;  // 1: write wins the next tie
  logic                  src_q, src_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  fetch_req_q, fetch_req_d;
  logic                  busy_q, busy_d;
  logic                  proto_err_q, proto_err_d;
  logic                  rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic                  rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic                  sel_wr;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    src_d       = src_q;
    cmd_d       = cmd_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    rd_gnt_d    = 1'b0;
    wr_gnt_d    = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    sel_wr      = wr_fetch_req && (!rd_fetch_req || rr_q);
    // A completion outside WAIT has no fetch to retire; flag it and otherwise ignore it.
    proto_err_d = proto_err_q || (fetch_done && (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (rd_fetch_req || wr_fetch_req) begin
          state_d = ISSUE;
          src_d   = sel_wr;
          rr_d    = !sel_wr;
          cmd_d   = sel_wr ? wr_fetch_cmd  : rd_fetch_cmd;
          tag_d   = sel_wr ? wr_fetch_tag  : rd_fetch_tag;
          addr_d  = sel_wr ? wr_fetch_addr : rd_fetch_addr;
        end
      end
      ISSUE: begin
        if (fetch_gnt) begin
          state_d  = WAIT;
          rd_gnt_d = !src_q;
          wr_gnt_d = src_q;
        end
      end
      WAIT: begin
        if (fetch_done) begin
          state_d   = IDLE;
          rd_done_d = !src_q;
          wr_done_d = src_q;
        end
      end
      default: state_d = IDLE;
    endcase
    fetch_req_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      src_q       <= 1'b0;
      cmd_q       <= '0;
      tag_q       <= '0;
      addr_q      <= '0;
      fetch_req_q <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      src_q       <= src_d;
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      fetch_req_q <= fetch_req_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
      rd_gnt_q    <= rd_gnt_d;
      wr_gnt_q    <= wr_gnt_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign rd_fetch_gnt  = rd_gnt_q;
  assign wr_fetch_gnt  = wr_gnt_q;
  assign rd_fetch_done = rd_done_q;
  assign wr_fetch_done = wr_done_q;
  assign fetch_req     = fetch_req_q;
  assign fetch_cmd     = cmd_q;
  assign fetch_tag     = tag_q;
  assign fetch_addr    = addr_q;
  assign fetch_src     = src_q;
  assign busy          = busy_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench for fetch_arbiter: directed stimulus pushes expected payloads and upstream pulses.
module tb_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [1:0]  rd_cmd, wr_cmd, rd_tag, wr_tag;
  logic [31:0] rd_addr, wr_addr;
  logic        rd_fetch_gnt, rd_fetch_done, wr_fetch_gnt, wr_fetch_done;
  logic        fetch_req, fetch_src, fetch_gnt, fetch_done, busy, proto_err;
  logic [1:0]  fetch_cmd, fetch_tag;
  logic [31:0] fetch_addr;

  int tests = 0;
  int fails = 0;

  // Event code {src, kind}: kind 0 = gnt, 1 = done
  logic [1:0]  exp_ev[$];
  logic [63:0] exp_pl[$];
  logic        req_prev;

  always #5 clk = ~clk;

  fetch_arbiter #(.addr_width(32), .list_depth(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_fetch_req(rd_req), .rd_fetch_cmd(rd_cmd), .rd_fetch_tag(rd_tag), .rd_fetch_addr(rd_addr),
    .rd_fetch_gnt(rd_fetch_gnt), .rd_fetch_done(rd_fetch_done),
    .wr_fetch_req(wr_req), .wr_fetch_cmd(wr_cmd), .wr_fetch_tag(wr_tag), .wr_fetch_addr(wr_addr),
    .wr_fetch_gnt(wr_fetch_gnt), .wr_fetch_done(wr_fetch_done),
    .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag), .fetch_addr(fetch_addr),
    .fetch_src(fetch_src), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pl(input logic src, input logic [1:0] cmd,
                                     input logic [1:0] tag, input logic [31:0] addr);
    return {27'd0, src, cmd, tag, addr};
  endfunction

  task automatic push_fetch(input logic src, input logic [1:0] cmd,
                            input logic [1:0] tag, input logic [31:0] addr);
    exp_pl.push_back(pl(src, cmd, tag, addr));
    exp_ev.push_back({src, 1'b0});
    exp_ev.push_back({src, 1'b1});
  endtask

  task automatic pop_ev(input string name, input logic [1:0] code);
    if (exp_ev.size() == 0) check({name, "_unexpected"}, {62'd0, code}, 64'hFF);
    else check(name, {62'd0, code}, {62'd0, exp_ev.pop_front()});
  endtask

  // Monitor: compares every upstream pulse and every new fetch_req payload against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
    end else begin
      if (rd_fetch_gnt)  pop_ev("rd_gnt",  2'b00);
      if (rd_fetch_done) pop_ev("rd_done", 2'b01);
      if (wr_fetch_gnt)  pop_ev("wr_gnt",  2'b10);
      if (wr_fetch_done) pop_ev("wr_done", 2'b11);
      if (rd_fetch_gnt | rd_fetch_done | wr_fetch_gnt | wr_fetch_done)
        check("rd_wr_exclusive", {63'd0, (rd_fetch_gnt | rd_fetch_done) & (wr_fetch_gnt | wr_fetch_done)}, 64'd0);
      if (fetch_req && !req_prev) begin
        if (exp_pl.size() == 0) check("payload_unexpected", pl(fetch_src, fetch_cmd, fetch_tag, fetch_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("payload", pl(fetch_src, fetch_cmd, fetch_tag, fetch_addr), exp_pl.pop_front());
      end
      req_prev <= fetch_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !fetch_req; i++) tick();
    check("fetch_req_arrives", {63'd0, fetch_req}, 64'd1);
  endtask

  // Downstream responder: gnt after gnt_dly cycles in ISSUE, done done_dly cycles after the gnt pulse.
  task automatic serve(input int gnt_dly, input int done_dly, input bit keep);
    wait_req();
    repeat (gnt_dly) tick();
    fetch_gnt = 1'b1;
    tick();
    fetch_gnt = 1'b0;
    if (!keep) begin
      if (rd_fetch_gnt) rd_req = 1'b0;
      if (wr_fetch_gnt) wr_req = 1'b0;
    end
    repeat (done_dly) tick();
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    check("idle_after_done", {63'd0, busy}, 64'd0);
    check("no_req_after_done", {63'd0, fetch_req}, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, proto_err, fetch_req, fetch_src, fetch_cmd, fetch_tag,
                 rd_fetch_gnt, rd_fetch_done, wr_fetch_gnt, wr_fetch_done}, 64'd0);
    check({name, "_addr"}, {32'd0, fetch_addr}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_req = 0; wr_req = 0; rd_cmd = 0; wr_cmd = 0; rd_tag = 0; wr_tag = 0;
    rd_addr = 0; wr_addr = 0; fetch_gnt = 0; fetch_done = 0;
    repeat (3) tick();
    check_all_zero("reset");

    // Both requesting from reset, immediate gnt/done: rd, wr, rd, wr
    rd_req = 1; rd_cmd = 2'd1; rd_tag = 2'd2; rd_addr = 32'h200;
    wr_req = 1; wr_cmd = 2'd3; wr_tag = 2'd3; wr_addr = 32'h300;
    push_fetch(0, 2'd1, 2'd2, 32'h200);
    push_fetch(1, 2'd3, 2'd3, 32'h300);
    push_fetch(0, 2'd1, 2'd2, 32'h200);
    push_fetch(1, 2'd3, 2'd3, 32'h300);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) serve(0, 0, 1);
    rd_req = 0; wr_req = 0;
    check("proto_err_same_cycle_done", {63'd0, proto_err}, 64'd0);
    repeat (2) tick();

    // Single read: one-cycle latency to fetch_req
    rd_req = 1; rd_cmd = 2'd2; rd_tag = 2'd1; rd_addr = 32'h100;
    push_fetch(0, 2'd2, 2'd1, 32'h100);
    tick();
    check("req_latency", {62'd0, fetch_req, busy}, 64'd3);
    serve(1, 3, 0);

    // Stalled ISSUE for 10 cycles; a write arriving meanwhile must not disturb the payload
    rd_req = 1; rd_cmd = 2'd0; rd_tag = 2'd3; rd_addr = 32'hABC0;
    push_fetch(0, 2'd0, 2'd3, 32'hABC0);
    push_fetch(1, 2'd1, 2'd0, 32'h999);
    wait_req();
    for (int i = 0; i < 10; i++) begin
      check("stall_req", {63'd0, fetch_req}, 64'd1);
      check("stall_payload", pl(fetch_src, fetch_cmd, fetch_tag, fetch_addr), pl(0, 2'd0, 2'd3, 32'hABC0));
      if (i == 3) begin
        wr_req = 1; wr_cmd = 2'd1; wr_tag = 2'd0; wr_addr = 32'h999;
      end
      tick();
    end
    serve(0, 1, 0);
    serve(1, 1, 0);
    repeat (2) tick();

    // Stray fetch_done in IDLE: sticky error, no pulses, next fetch still works
    fetch_done = 1;
    tick();
    fetch_done = 0;
    check("proto_err_set", {63'd0, proto_err}, 64'd1);
    check("stray_done_idle", {63'd0, busy}, 64'd0);
    wr_req = 1; wr_cmd = 2'd2; wr_tag = 2'd2; wr_addr = 32'h4000;
    push_fetch(1, 2'd2, 2'd2, 32'h4000);
    serve(1, 2, 0);
    check("proto_err_sticky", {63'd0, proto_err}, 64'd1);

    // Reset during WAIT of a write fetch, then rd wins first
    wr_req = 1; wr_cmd = 2'd2; wr_tag = 2'd1; wr_addr = 32'h5000;
    exp_pl.push_back(pl(1, 2'd2, 2'd1, 32'h5000));
    exp_ev.push_back(2'b10);
    wait_req();
    fetch_gnt = 1;
    tick();
    fetch_gnt = 0;
    wr_req = 0;
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    rd_req = 1; rd_cmd = 2'd3; rd_tag = 2'd0; rd_addr = 32'h600;
    wr_req = 1; wr_cmd = 2'd1; wr_tag = 2'd1; wr_addr = 32'h700;
    push_fetch(0, 2'd3, 2'd0, 32'h600);
    push_fetch(1, 2'd1, 2'd1, 32'h700);
    tick();
    rst_n = 1'b1;
    serve(0, 0, 0);
    serve(0, 1, 0);
    check("proto_err_after_reset", {63'd0, proto_err}, 64'd0);
    repeat (3) tick();

    check("events_left", exp_ev.size(), 64'd0);
    check("payloads_left", exp_pl.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
